// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-enabled data memory: funct3 codes, FSM states,
// and the byte-enable / store-replication / load-extension / error helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {CLEAR, RUN} state_t;

  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_B:    be_gen = 4'b0001 << lane;
      F3_H:    be_gen = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    be_gen = 4'b1111;
      default: be_gen = 4'b0000;
    endcase
  endfunction

  // Replicate narrow store data across the word so the byte enables pick the lane.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_B:    store_data = {4{wdata[7:0]}};
      F3_H:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_BU:   load_ext = {24'h0, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_HU:   load_ext = {16'h0, h};
      F3_W:    load_ext = word;
      default: load_ext = 32'h0;
    endcase
  endfunction

  function automatic logic op_err(input logic we, input logic [2:0] f3, input logic [1:0] lane);
    logic illegal;
    logic misaligned;
    illegal    = we ? (f3[2] || (f3[1:0] == 2'b11))
                    : ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
    misaligned = ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
    op_err = illegal || misaligned;
  endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read port.
module dmem_ram_be #(
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [IW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/data_mem_be.sv
// Byte-addressable RV32 data memory: byte/half/word stores, extended loads, error flag.
// Define DMEM_CLEAR_EN to zero-fill the array after every reset before accepting requests.
module data_mem_be
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          init_done
);

  localparam int IW = $clog2(DEPTH);

  logic          w_accept;
  logic          w_err;
  logic          w_clearing;
  logic [IW-1:0] w_clr_idx;
  logic [3:0]    w_ram_we;
  logic [IW-1:0] w_ram_addr;
  logic [31:0]   w_ram_wdata;
  logic [31:0]   w_ram_rdata;
  logic          w_unused_addr;

  logic          r_resp_valid;
  logic          r_resp_err;
  logic          r_load_ok;
  logic [2:0]    r_f3;
  logic [1:0]    r_lane;

`ifdef DMEM_CLEAR_EN
  state_t        r_state;
  logic [IW-1:0] r_clr_idx;
  logic          r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_clr_idx <= r_clr_idx + 1'b1;
      if (r_clr_idx == IW'(DEPTH - 1)) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end
    end
  end

  assign w_clearing = (r_state == CLEAR) && !rst;
  assign w_clr_idx  = r_clr_idx;
  assign req_ready  = r_ready;
  assign init_done  = r_ready;
`else
  assign w_clearing = 1'b0;
  assign w_clr_idx  = '0;
  assign req_ready  = 1'b1;
  assign init_done  = 1'b1;
`endif

  // Upper address bits beyond the word index are deliberately ignored (address wrap).
  assign w_unused_addr = &{1'b0, req_addr};

  assign w_accept    = req_valid && req_ready && !rst;
  assign w_err       = op_err(req_we, req_funct3, req_addr[1:0]);
  assign w_ram_we    = w_clearing ? 4'hF
                     : (w_accept && req_we && !w_err) ? be_gen(req_funct3, req_addr[1:0])
                     : 4'h0;
  assign w_ram_addr  = w_clearing ? w_clr_idx : req_addr[IW+1:2];
  assign w_ram_wdata = w_clearing ? 32'h0 : store_data(req_funct3, req_wdata);

  dmem_ram_be #(.DEPTH(DEPTH), .IW(IW)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_load_ok    <= 1'b0;
      r_f3         <= 3'b000;
      r_lane       <= 2'b00;
    end else begin
      r_resp_valid <= w_accept;
      r_resp_err   <= w_accept && w_err;
      r_load_ok    <= w_accept && !req_we && !w_err;
      r_f3         <= req_funct3;
      r_lane       <= req_addr[1:0];
    end
  end

  // The RAM output register holds the word; extension is applied to it on the way out.
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_load_ok ? load_ext(r_f3, r_lane, w_ram_rdata) : 32'h0;

endmodule

// File: tb/tb_data_mem_be.sv
// Scoreboard bench for data_mem_be: byte-level reference model, randomized traffic,
// per-cycle response-timing check, and reset behaviour (clear sequence if DMEM_CLEAR_EN).
module tb_data_mem_be;
  import dmem_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  data_mem_be #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb_q[$];
  byte unsigned mem_b [4*DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          n_resp = 0;
  bit          prev_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: byte array indexed by address modulo memory size.
  function automatic void model(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wd, output bit err, output logic [31:0] rd);
    int          idx;
    int          size;
    bit          legal;
    logic [31:0] val;
    idx  = int'(addr % (4*DEPTH));
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err  = !legal || ((idx % size) != 0);
    rd   = 32'h0;
    if (err) return;
    if (we) begin
      for (int k = 0; k < size; k++) mem_b[idx+k] = wd[8*k +: 8];
    end else begin
      val = 32'h0;
      for (int k = 0; k < size; k++) val[8*k +: 8] = mem_b[idx+k];
      if (!f3[2] && size == 1) val = {{24{val[7]}}, val[7:0]};
      if (!f3[2] && size == 2) val = {{16{val[15]}}, val[15:0]};
      rd = val;
    end
  endfunction

  // Monitor: resp_valid must mirror the acceptance one edge earlier; pop on each response.
  always @(negedge clk) begin
    exp_t e;
    chk("resp_valid_timing", {31'h0, resp_valid}, {31'h0, prev_acc});
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=response expected=none");
      end else begin
        e = sb_q.pop_front();
        n_resp++;
        $display("RESP %0d err=%0b rdata=%h (exp err=%0b rdata=%h)",
                 n_resp, resp_err, resp_rdata, e.err, e.rd);
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_rdata", resp_rdata, e.rd);
      end
    end
    prev_acc = req_valid && req_ready && !rst;
  end

  task automatic issue(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    @(negedge clk);
    if (req_ready && !rst) begin
      model(we, addr, f3, wd, e.err, e.rd);
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (n < 4*DEPTH) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
`ifdef DMEM_CLEAR_EN
    chk(name, n, DEPTH);
    for (int i = 0; i < 4*DEPTH; i++) mem_b[i] = 8'h00;
`else
    chk(name, n, 0);
`endif
    chk("init_done", {31'h0, init_done}, 32'h1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
`ifdef DMEM_CLEAR_EN
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_init_done", {31'h0, init_done}, 32'h0);
`else
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_init_done", {31'h0, init_done}, 32'h1);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready("clear_cycles");

`ifdef DMEM_CLEAR_EN
    issue(1'b0, 32'h3C, F3_W, 32'h0);
`endif
    for (int w = 0; w < DEPTH; w++) issue(1'b1, 32'(4*w), F3_W, $urandom);

    // Mixed-width data path
    issue(1'b1, 32'h10, F3_W,  32'h80FF7F01);
    issue(1'b0, 32'h10, F3_W,  32'h0);
    issue(1'b0, 32'h13, F3_B,  32'h0);
    issue(1'b0, 32'h13, F3_BU, 32'h0);
    issue(1'b0, 32'h12, F3_H,  32'h0);
    issue(1'b0, 32'h12, F3_HU, 32'h0);
    issue(1'b1, 32'h20, F3_W,  32'h11223344);
    issue(1'b1, 32'h21, F3_B,  32'h000000AA);
    issue(1'b0, 32'h20, F3_W,  32'h0);
    issue(1'b1, 32'h22, F3_H,  32'h0000BEEF);
    issue(1'b0, 32'h20, F3_W,  32'h0);
    // Errors must not disturb memory
    issue(1'b1, 32'h22, F3_W,  32'hDEADBEEF);
    issue(1'b0, 32'h01, F3_H,  32'h0);
    issue(1'b0, 32'h20, 3'b011, 32'h0);
    issue(1'b1, 32'h20, 3'b100, 32'h12345678);
    issue(1'b0, 32'h20, F3_W,  32'h0);
    // Address wrap modulo 4*DEPTH
    issue(1'b1, 32'(4*DEPTH), F3_W, 32'h00000005);
    issue(1'b0, 32'h0, F3_W, 32'h0);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else issue(1'($urandom_range(1)), $urandom, 3'($urandom_range(7)), $urandom);
    end

    // Reset during the acceptance cycle of a load
    @(posedge clk);
    #1;
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = F3_W;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    wait_ready("clear_cycles_after_rst");
    issue(1'b0, 32'h20, F3_W, 32'h0);
    issue(1'b0, 32'h10, F3_W, 32'h0);
    idle(3);
    @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
